// File: rtl/lycan_globals_pkg.sv
// Shared USB/peripheral sizing and types for the lycan transmit and receive arbiters.
// Pure declarations: no logic, no latency, no flow control.
package lycan_globals;

    localparam int num_peripherals      = 8;
    localparam int usb_packet_width     = 32;
    localparam int periph_address_width = 3;
    localparam int usb_payload_width    = usb_packet_width - periph_address_width;
    localparam int tx_max_burst         = 4;

    typedef logic [periph_address_width-1:0] periph_addr_t;
    typedef logic [usb_payload_width-1:0]    usb_payload_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lycan_rr_picker.sv
// Rotating priority encoder: first set req bit after rr_last, wrapping. Purely combinational.
// No backpressure; any=0 when no request is pending.
module lycan_rr_picker #(
    parameter int N      = 8,
    parameter int ADDR_W = 3
) (
    input  logic [N-1:0]      req,
    input  logic [ADDR_W-1:0] rr_last,
    output logic [ADDR_W-1:0] winner,
    output logic              any
);

    logic [ADDR_W-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int off = 1; off <= N; off++) begin
            idx = ADDR_W'((int'(rr_last) + off) % N);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/lycan_tx_arbiter.sv
// Round-robin arbiter sharing the USB TX packet stream; bounded bursts, address stamped in header.
// Latency: request to out_valid is 2 cycles; out_ready low stalls the granted source via periph_ready.
module lycan_tx_arbiter
    import lycan_globals::*;
#(
    parameter int NUM_PERIPHS = num_peripherals,
    parameter int PACKET_W    = usb_packet_width,
    parameter int ADDR_W      = periph_address_width,
    parameter int PAYLOAD_W   = PACKET_W - ADDR_W,
    parameter int MAX_BURST   = tx_max_burst
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PERIPHS-1:0]                enable_mask,
    input  logic [NUM_PERIPHS-1:0]                periph_valid,
    input  logic [NUM_PERIPHS-1:0][PAYLOAD_W-1:0] periph_payload,
    output logic [NUM_PERIPHS-1:0]                periph_ready,
    output logic                                  out_valid,
    output logic [PACKET_W-1:0]                   out_data,
    input  logic                                  out_ready,
    output logic                                  grant_active,
    output logic [ADDR_W-1:0]                     grant_id
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(MAX_BURST - 1);
    localparam logic [ADDR_W-1:0] RR_LAST_RST = ADDR_W'(NUM_PERIPHS - 1);

    arb_state_t            state_q, state_d;
    logic [ADDR_W-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0]     rr_last_q, rr_last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_d;
    logic [PACKET_W-1:0]   out_data_d;

    logic [NUM_PERIPHS-1:0] req;
    logic                   slot_free;
    logic                   grant_req;
    logic                   accept;
    logic [ADDR_W-1:0]      pick_winner;
    logic                   pick_any;

    assign req       = periph_valid & enable_mask;
    assign slot_free = !out_valid || out_ready;
    assign grant_req = req[grant_q];
    assign accept    = (state_q == ARB_BURST) && grant_req && slot_free;

    lycan_rr_picker #(
        .N      (NUM_PERIPHS),
        .ADDR_W (ADDR_W)
    ) u_picker (
        .req     (req),
        .rr_last (rr_last_q),
        .winner  (pick_winner),
        .any     (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_last_d    = rr_last_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid;
        out_data_d   = out_data;
        periph_ready = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d   = pick_winner;
                    rr_last_d = pick_winner;
                    cnt_d     = '0;
                    state_d   = ARB_BURST;
                end
            end
            ARB_BURST: begin
                periph_ready[grant_q] = accept;
                // A dropped request forfeits the burst; a stall simply holds everything.
                if (!grant_req) begin
                    state_d = ARB_IDLE;
                end else if (accept) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ARB_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = {grant_q, periph_payload[grant_q]};
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            rr_last_q <= RR_LAST_RST;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

    assign grant_active = (state_q == ARB_BURST);
    assign grant_id     = grant_q;

endmodule

// File: tb/tb_lycan_tx_arbiter.sv
// Directed bench for lycan_tx_arbiter with an ownership/queue-level reference model checked every cycle.
module tb_lycan_tx_arbiter;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int PW = 29;
    localparam int MB = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         enable_mask;
    logic [N-1:0]         periph_valid;
    logic [N-1:0][PW-1:0] periph_payload;
    logic [N-1:0]         periph_ready;
    logic                 out_valid;
    logic [31:0]          out_data;
    logic                 out_ready;
    logic                 grant_active;
    logic [AW-1:0]        grant_id;

    always #5 clk = ~clk;

    lycan_tx_arbiter #(
        .NUM_PERIPHS (N),
        .PACKET_W    (32),
        .ADDR_W      (AW),
        .PAYLOAD_W   (PW),
        .MAX_BURST   (MB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_mask    (enable_mask),
        .periph_valid   (periph_valid),
        .periph_payload (periph_payload),
        .periph_ready   (periph_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .grant_active   (grant_active),
        .grant_id       (grant_id)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Sources: remaining packet count and next payload per peripheral.
    int          src_left [N];
    logic [PW-1:0] src_pay [N];

    // Reference model: who owns the stream, how many taken, rotation pointer, output slot.
    bit          m_known = 1'b0;
    int          m_owner, m_taken, m_last, m_gid;
    bit          m_vld;
    logic [31:0] m_dat;

    int          obs_cyc [$];
    logic [31:0] obs_dat [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            periph_valid[i]   = (src_left[i] > 0);
            periph_payload[i] = src_pay[i];
        end
    endtask

    task automatic model_cycle();
        logic [N-1:0] reqv;
        logic [N-1:0] exp_rdy;
        bit           found;
        int           c;
        reqv    = periph_valid & enable_mask;
        exp_rdy = '0;
        found   = 1'b0;
        if (m_known && m_owner >= 0 && reqv[m_owner] && (!m_vld || out_ready))
            exp_rdy[m_owner] = 1'b1;
        if (m_known) begin
            chk("ready", 32'(periph_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_vld));
            if (m_vld) chk("out_data", out_data, m_dat);
            chk("grant_active", 32'(grant_active), 32'(m_owner >= 0));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
        end
        if (out_valid && out_ready) begin
            obs_cyc.push_back(cyc);
            obs_dat.push_back(out_data);
        end
        if (!rst_n) begin
            m_known = 1'b1;
            m_owner = -1;
            m_taken = 0;
            m_last  = N - 1;
            m_gid   = 0;
            m_vld   = 1'b0;
            m_dat   = '0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (periph_valid[i] && periph_ready[i]) begin
                src_left[i]--;
                src_pay[i]++;
            end
        end
        if (!m_known) return;
        if (exp_rdy != '0) begin
            m_vld = 1'b1;
            m_dat = {AW'(m_owner), periph_payload[m_owner]};
        end else if (out_ready) begin
            m_vld = 1'b0;
        end
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && reqv[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_gid   = c;
                    m_taken = 0;
                end
            end
        end else if (!reqv[m_owner]) begin
            m_owner = -1;
        end else if (exp_rdy != '0) begin
            m_taken++;
            if (m_taken == MB) m_owner = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) src_left[i] = 0;
        drive();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        obs_cyc.delete();
        obs_dat.delete();
    endtask

    int c0;
    int cnt [N];
    int cmin, cmax, n2;

    initial begin
        rst_n       = 1'b0;
        enable_mask = '1;
        out_ready   = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_left[i] = 1;
            src_pay[i]  = '0;
        end
        drive();
        @(posedge clk);
        #1;

        // Reset held with every source requesting.
        run(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_ready", 32'(periph_ready), 32'd0);
        chk("rst_grant_active", 32'(grant_active), 32'd0);
        rst_n = 1'b1;
        step();
        chk("first_grant_id", 32'(grant_id), 32'd0);
        chk("first_grant_active", 32'(grant_active), 32'd1);
        clear_src();
        run(3);

        // Single requester, periph 5.
        obs_cyc.delete();
        obs_dat.delete();
        src_pay[5]  = 29'd1;
        src_left[5] = 3;
        c0 = cyc;
        drive();
        run(8);
        chk("single_count", 32'(obs_dat.size()), 32'd3);
        if (obs_dat.size() == 3) begin
            chk("single_first_cycle", 32'(obs_cyc[0] - c0), 32'd2);
            chk("single_pkt0", obs_dat[0], 32'hA000_0001);
            chk("single_pkt1", obs_dat[1], 32'hA000_0002);
            chk("single_pkt2", obs_dat[2], 32'hA000_0003);
            chk("single_back_to_back", 32'(obs_cyc[2] - obs_cyc[0]), 32'd2);
        end

        // Full contention from a fresh rotation pointer.
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            src_left[i] = 1000;
            src_pay[i]  = PW'(i * 4096);
        end
        c0 = cyc;
        drive();
        run(80);
        clear_src();
        run(3);
        chk("cont_enough", 32'(obs_dat.size() >= 36), 32'd1);
        if (obs_dat.size() >= 36) begin
            chk("cont_first_cycle", 32'(obs_cyc[0] - c0), 32'd2);
            chk("cont_intra_burst", 32'(obs_cyc[1] - obs_cyc[0]), 32'd1);
            chk("cont_bubble", 32'(obs_cyc[4] - obs_cyc[3]), 32'd2);
            for (int k = 0; k < 36; k++)
                chk("cont_order", 32'(obs_dat[k][31:29]), 32'((k / 4) % 8));
        end
        for (int i = 0; i < N; i++) cnt[i] = 0;
        foreach (obs_dat[k]) cnt[obs_dat[k][31:29]]++;
        cmin = cnt[0];
        cmax = cnt[0];
        for (int i = 1; i < N; i++) begin
            if (cnt[i] < cmin) cmin = cnt[i];
            if (cnt[i] > cmax) cmax = cnt[i];
        end
        chk("cont_fairness", 32'(cmax - cmin <= 4), 32'd1);

        // Backpressure mid-burst from periph 3.
        obs_cyc.delete();
        obs_dat.delete();
        src_pay[3]  = 29'h10;
        src_left[3] = 4;
        drive();
        run(3);
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, 32'h6000_0011);
            chk("stall_ready", 32'(periph_ready), 32'd0);
        end
        out_ready = 1'b1;
        run(6);
        chk("bp_count", 32'(obs_dat.size()), 32'd4);
        if (obs_dat.size() == 4) begin
            for (int k = 0; k < 4; k++)
                chk("bp_seq", obs_dat[k], 32'h6000_0010 + 32'(k));
        end

        // Masking periph 2 after its first accept.
        pulse_reset();
        src_left[2] = 1000;
        src_left[3] = 1000;
        drive();
        run(2);
        chk("mask_pre_ready", 32'(periph_ready), 32'h04);
        enable_mask[2] = 1'b0;
        #1;
        chk("mask_ready_drop", 32'(periph_ready), 32'd0);
        step();
        chk("mask_idle", 32'(grant_active), 32'd0);
        step();
        chk("mask_next_grant", 32'(grant_id), 32'd3);
        chk("mask_next_active", 32'(grant_active), 32'd1);
        run(20);
        n2 = 0;
        foreach (obs_dat[k]) if (obs_dat[k][31:29] == 3'd2) n2++;
        chk("mask_p2_packets", 32'(n2), 32'd1);
        clear_src();
        enable_mask = '1;
        run(3);

        // Reset in the middle of a periph 6 burst.
        src_left[6] = 1000;
        drive();
        run(3);
        chk("pre_rst_grant", 32'(grant_id), 32'd6);
        rst_n = 1'b0;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_active", 32'(grant_active), 32'd0);
        chk("midrst_grant_id", 32'(grant_id), 32'd0);
        chk("midrst_ready", 32'(periph_ready), 32'd0);
        rst_n = 1'b1;
        src_left[0] = 1000;
        drive();
        step();
        chk("restart_grant", 32'(grant_id), 32'd0);
        chk("restart_active", 32'(grant_active), 32'd1);
        run(4);
        clear_src();
        run(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
